// File: rtl/adc_sample_router_pkg.sv
// Purpose : Shared constants and helpers for the ADC sample router.
//           Defaults match the ADC controller and PID core: 18-bit samples,
//           6 channels, and a 3-bit channel index. Channels 0..N/2-1 arrive on
//           serial port A. The remaining channels arrive on port B.
// Ports   : none (package)
package adc_sample_router_pkg;

    localparam int DEF_W_OUT  = 18;
    localparam int DEF_N_CHAN = 6;
    localparam int DEF_W_CHAN = 3;
    // Number of channels carried by each serial port.
    localparam int N_PORT_CH  = DEF_N_CHAN / 2;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Returns the serial port that carries channel k.
    function automatic port_e chan_port(input int k, input int n_chan);
        return (k < n_chan / 2) ? PORT_A : PORT_B;
    endfunction

endpackage

// File: rtl/adc_sample_router_if.sv
// Purpose : Tagged sample stream from the router to the PID core.
// Ports   : data_out (signed sample), chan_out (channel tag) and
//           dv_out (valid) are driven by the master (the router).
//           ready_in (ready) is driven by the slave (the PID core).
interface adc_sample_router_if
    import adc_sample_router_pkg::*;
#(
    parameter int W_OUT  = DEF_W_OUT,
    parameter int W_CHAN = DEF_W_CHAN
) ();

    logic signed [W_OUT-1:0]  data_out;
    logic        [W_CHAN-1:0] chan_out;
    logic                     dv_out;
    logic                     ready_in;

    modport master (
        output data_out,
        output chan_out,
        output dv_out,
        input  ready_in
    );

    modport slave (
        input  data_out,
        input  chan_out,
        input  dv_out,
        output ready_in
    );

endinterface

// File: rtl/adc_sample_router_rr_arbiter.sv
// Purpose : Combinational rotating-priority arbiter. It grants the first set
//           request found by searching upward from ptr_i and wrapping at N.
// Ports   : req_i       request vector
//           ptr_i       starting search position (0..N-1)
//           gnt_valid_o some request was granted
//           gnt_idx_o   granted index (0 when nothing is granted)
module rr_arbiter
    import adc_sample_router_pkg::*;
#(
    parameter int N = DEF_N_CHAN,
    parameter int W = DEF_W_CHAN
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         gnt_valid_o,
    output logic [W-1:0] gnt_idx_o
);

    // Walk the offsets from the farthest to the nearest so that the nearest
    // request overwrites any farther one.
    always_comb begin
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int j;
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (req_i[j]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = W'(j);
            end
        end
    end

endmodule

// File: rtl/adc_sample_router.sv
// Purpose : Captures per-channel ADC samples, buffers one sample per channel,
//           and serializes them round-robin onto a valid/ready stream tagged
//           with the channel index. It also flags overwritten, unsent samples.
// Ports   : clk_in         clock (rising edge)
//           n_reset_in     asynchronous active-low reset
//           data_valid_in  per-channel capture strobes
//           data_a_in      port A sample (channels 0..N_CHAN/2-1)
//           data_b_in      port B sample (channels N_CHAN/2..N_CHAN-1)
//           chan_en_in     enable mask, latched on update_in
//           update_in      enable-mask latch strobe
//           clr_ovr_in     clears the overrun flags
//           ovr_out        sticky per-channel overrun flags
//           out_if         tagged output stream (master side)
module adc_sample_router
    import adc_sample_router_pkg::*;
#(
    parameter int W_OUT  = DEF_W_OUT,
    parameter int N_CHAN = DEF_N_CHAN,
    parameter int W_CHAN = DEF_W_CHAN
) (
    input  logic                     clk_in,
    input  logic                     n_reset_in,
    input  logic        [N_CHAN-1:0] data_valid_in,
    input  logic signed [W_OUT-1:0]  data_a_in,
    input  logic signed [W_OUT-1:0]  data_b_in,
    input  logic        [N_CHAN-1:0] chan_en_in,
    input  logic                     update_in,
    input  logic                     clr_ovr_in,
    output logic        [N_CHAN-1:0] ovr_out,
    adc_sample_router_if.master      out_if
);

    logic signed [W_OUT-1:0]  hold_q [N_CHAN];
    logic signed [W_OUT-1:0]  hold_d [N_CHAN];
    logic        [N_CHAN-1:0] pending_q, pending_d;
    logic        [N_CHAN-1:0] ovr_q, ovr_d;
    logic        [N_CHAN-1:0] chan_en_q, chan_en_d;
    logic signed [W_OUT-1:0]  data_q, data_d;
    logic        [W_CHAN-1:0] chan_q, chan_d;
    logic                     dv_q, dv_d;
    logic        [W_CHAN-1:0] rr_ptr_q, rr_ptr_d;

    logic                     gnt_valid;
    logic        [W_CHAN-1:0] gnt_idx;
    logic                     unload;

    rr_arbiter #(.N(N_CHAN), .W(W_CHAN)) u_arb (
        .req_i       (pending_q),
        .ptr_i       (rr_ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    // The output register may be reloaded when it is empty or being accepted.
    assign unload = !dv_q || out_if.ready_in;

    always_comb begin
        pending_d = pending_q;
        ovr_d     = clr_ovr_in ? '0 : ovr_q;
        chan_en_d = update_in ? chan_en_in : chan_en_q;
        data_d    = data_q;
        chan_d    = chan_q;
        dv_d      = dv_q;
        rr_ptr_d  = rr_ptr_q;

        for (int k = 0; k < N_CHAN; k++) begin
            logic cap;
            logic unl;
            cap       = data_valid_in[k] && chan_en_q[k];
            unl       = unload && gnt_valid && (gnt_idx == W_CHAN'(k));
            hold_d[k] = hold_q[k];
            if (cap) begin
                hold_d[k] = (chan_port(k, N_CHAN) == PORT_A) ? data_a_in : data_b_in;
            end
            // A capture re-arms the slot even if the old value is leaving now.
            pending_d[k] = (pending_q[k] && !unl) || cap;
            // A set here overrides clr_ovr_in, so a coincident overrun is kept.
            if (cap && pending_q[k] && !unl) ovr_d[k] = 1'b1;
            if (update_in && !chan_en_in[k]) pending_d[k] = 1'b0;
        end

        if (unload) begin
            if (gnt_valid) begin
                data_d   = hold_q[gnt_idx];
                chan_d   = gnt_idx;
                dv_d     = 1'b1;
                rr_ptr_d = (gnt_idx == W_CHAN'(N_CHAN - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                dv_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            for (int k = 0; k < N_CHAN; k++) hold_q[k] <= '0;
            pending_q <= '0;
            ovr_q     <= '0;
            chan_en_q <= '1;
            data_q    <= '0;
            chan_q    <= '0;
            dv_q      <= 1'b0;
            rr_ptr_q  <= '0;
        end else begin
            for (int k = 0; k < N_CHAN; k++) hold_q[k] <= hold_d[k];
            pending_q <= pending_d;
            ovr_q     <= ovr_d;
            chan_en_q <= chan_en_d;
            data_q    <= data_d;
            chan_q    <= chan_d;
            dv_q      <= dv_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign ovr_out         = ovr_q;
    assign out_if.data_out = data_q;
    assign out_if.chan_out = chan_q;
    assign out_if.dv_out   = dv_q;

endmodule

// File: tb/tb_adc_sample_router.sv
module tb_adc_sample_router;

    logic               clk_in = 1'b0;
    logic               n_reset_in;
    logic        [5:0]  data_valid_in;
    logic signed [17:0] data_a_in;
    logic signed [17:0] data_b_in;
    logic        [5:0]  chan_en_in;
    logic               update_in;
    logic               clr_ovr_in;
    logic        [5:0]  ovr_out;

    int n_checks = 0;
    int n_fail   = 0;

    adc_sample_router_if #(.W_OUT(18), .W_CHAN(3)) out_if ();

    adc_sample_router #(.W_OUT(18), .N_CHAN(6), .W_CHAN(3)) dut (
        .clk_in        (clk_in),
        .n_reset_in    (n_reset_in),
        .data_valid_in (data_valid_in),
        .data_a_in     (data_a_in),
        .data_b_in     (data_b_in),
        .chan_en_in    (chan_en_in),
        .update_in     (update_in),
        .clr_ovr_in    (clr_ovr_in),
        .ovr_out       (ovr_out),
        .out_if        (out_if.master)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        n_reset_in        = 1'b0;
        data_valid_in     = '0;
        data_a_in         = '0;
        data_b_in         = '0;
        chan_en_in        = '1;
        update_in         = 1'b0;
        clr_ovr_in        = 1'b0;
        out_if.ready_in   = 1'b0;
        repeat (2) tick();
        n_reset_in = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_if.dv_out !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %0b want 0", out_if.dv_out); end
        n_checks++;
        if (out_if.data_out !== 18'sd0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_if.data_out); end
        n_checks++;
        if (out_if.chan_out !== 3'd0) begin n_fail++; $display("FAIL reset_chan got %0d want 0", out_if.chan_out); end
        n_checks++;
        if (ovr_out !== 6'b0) begin n_fail++; $display("FAIL reset_ovr got %b want 0", ovr_out); end
    endtask

    task automatic test_single();
        do_reset();
        data_valid_in = 6'b000001;
        data_a_in     = 18'sh12345;
        tick();
        data_valid_in = '0;
        n_checks++;
        if (out_if.dv_out !== 1'b0) begin n_fail++; $display("FAIL single_latency got %0b want 0", out_if.dv_out); end
        tick();
        n_checks++;
        if (out_if.dv_out !== 1'b1) begin n_fail++; $display("FAIL single_dv got %0b want 1", out_if.dv_out); end
        n_checks++;
        if (out_if.chan_out !== 3'd0) begin n_fail++; $display("FAIL single_chan got %0d want 0", out_if.chan_out); end
        n_checks++;
        if (out_if.data_out !== 18'sh12345) begin n_fail++; $display("FAIL single_data got %h want 12345", out_if.data_out); end
        out_if.ready_in = 1'b1;
        tick();
        n_checks++;
        if (out_if.dv_out !== 1'b0) begin n_fail++; $display("FAIL single_drain got %0b want 0", out_if.dv_out); end
    endtask

    task automatic test_pair();
        do_reset();
        out_if.ready_in = 1'b1;
        data_valid_in   = 6'b001001;
        data_a_in       = 18'sd100;
        data_b_in       = -18'sd5;
        tick();
        data_valid_in = '0;
        tick();
        n_checks++;
        if (out_if.dv_out !== 1'b1 || out_if.chan_out !== 3'd0 || out_if.data_out !== 18'sd100) begin
            n_fail++;
            $display("FAIL pair_first got dv=%0b ch=%0d d=%0d want dv=1 ch=0 d=100",
                     out_if.dv_out, out_if.chan_out, out_if.data_out);
        end
        tick();
        n_checks++;
        if (out_if.dv_out !== 1'b1 || out_if.chan_out !== 3'd3 || out_if.data_out !== -18'sd5) begin
            n_fail++;
            $display("FAIL pair_second got dv=%0b ch=%0d d=%0d want dv=1 ch=3 d=-5",
                     out_if.dv_out, out_if.chan_out, out_if.data_out);
        end
        tick();
        n_checks++;
        if (out_if.dv_out !== 1'b0) begin n_fail++; $display("FAIL pair_drain got %0b want 0", out_if.dv_out); end
    endtask

    task automatic test_overrun();
        do_reset();
        // Park channel 0 in the output so channel 1 stays buffered.
        data_valid_in = 6'b000001;
        data_a_in     = 18'sd11;
        tick();
        data_valid_in = '0;
        tick();
        data_valid_in = 6'b000010;
        data_a_in     = 18'sd7;
        tick();
        data_a_in = 18'sd9;
        tick();
        data_valid_in = '0;
        n_checks++;
        if (ovr_out !== 6'b000010) begin n_fail++; $display("FAIL ovr_set got %b want 000010", ovr_out); end
        tick();
        n_checks++;
        if (out_if.dv_out !== 1'b1 || out_if.chan_out !== 3'd0 || out_if.data_out !== 18'sd11) begin
            n_fail++;
            $display("FAIL ovr_stall got dv=%0b ch=%0d d=%0d want dv=1 ch=0 d=11",
                     out_if.dv_out, out_if.chan_out, out_if.data_out);
        end
        out_if.ready_in = 1'b1;
        tick();
        n_checks++;
        if (out_if.chan_out !== 3'd1 || out_if.data_out !== 18'sd9) begin
            n_fail++;
            $display("FAIL ovr_newest got ch=%0d d=%0d want ch=1 d=9", out_if.chan_out, out_if.data_out);
        end
        tick();
        clr_ovr_in = 1'b1;
        tick();
        clr_ovr_in = 1'b0;
        n_checks++;
        if (ovr_out !== 6'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 000000", ovr_out); end
        // An overrun that coincides with the clear strobe stays flagged.
        out_if.ready_in = 1'b0;
        data_valid_in   = 6'b000001;
        data_a_in       = 18'sd1;
        tick();
        data_valid_in = '0;
        tick();
        data_valid_in = 6'b000010;
        data_a_in     = 18'sd2;
        tick();
        data_a_in  = 18'sd3;
        clr_ovr_in = 1'b1;
        tick();
        data_valid_in = '0;
        clr_ovr_in    = 1'b0;
        n_checks++;
        if (ovr_out !== 6'b000010) begin n_fail++; $display("FAIL ovr_vs_clear got %b want 000010", ovr_out); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        out_if.ready_in = 1'b1;
        data_valid_in   = 6'b000100;
        data_a_in       = 18'sd21;
        tick();
        data_a_in = 18'sd22;
        tick();
        data_valid_in = '0;
        n_checks++;
        if (out_if.dv_out !== 1'b1 || out_if.chan_out !== 3'd2 || out_if.data_out !== 18'sd21) begin
            n_fail++;
            $display("FAIL same_old got dv=%0b ch=%0d d=%0d want dv=1 ch=2 d=21",
                     out_if.dv_out, out_if.chan_out, out_if.data_out);
        end
        n_checks++;
        if (ovr_out !== 6'b0) begin n_fail++; $display("FAIL same_noovr got %b want 000000", ovr_out); end
        tick();
        n_checks++;
        if (out_if.dv_out !== 1'b1 || out_if.chan_out !== 3'd2 || out_if.data_out !== 18'sd22) begin
            n_fail++;
            $display("FAIL same_new got dv=%0b ch=%0d d=%0d want dv=1 ch=2 d=22",
                     out_if.dv_out, out_if.chan_out, out_if.data_out);
        end
        tick();
        n_checks++;
        if (out_if.dv_out !== 1'b0) begin n_fail++; $display("FAIL same_drain got %0b want 0", out_if.dv_out); end
    endtask

    task automatic test_round_robin();
        logic [2:0]         exp_c [6];
        logic signed [17:0] exp_d [6];
        exp_c = '{3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
        exp_d = '{18'sd104, 18'sd105, 18'sd100, 18'sd101, 18'sd102, 18'sd103};
        do_reset();
        // Forward channel 3 once so the pointer moves to 4.
        out_if.ready_in = 1'b1;
        data_valid_in   = 6'b001000;
        data_b_in       = 18'sd33;
        tick();
        data_valid_in = '0;
        repeat (2) tick();
        out_if.ready_in = 1'b0;
        data_valid_in   = 6'b010010;
        data_a_in       = 18'sd101;
        data_b_in       = 18'sd104;
        tick();
        data_valid_in = 6'b001001;
        data_a_in     = 18'sd100;
        data_b_in     = 18'sd103;
        tick();
        data_valid_in = 6'b100100;
        data_a_in     = 18'sd102;
        data_b_in     = 18'sd105;
        tick();
        data_valid_in   = '0;
        out_if.ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (out_if.dv_out !== 1'b1 || out_if.chan_out !== exp_c[i] || out_if.data_out !== exp_d[i]) begin
                n_fail++;
                $display("FAIL rr_order[%0d] got dv=%0b ch=%0d d=%0d want dv=1 ch=%0d d=%0d", i,
                         out_if.dv_out, out_if.chan_out, out_if.data_out, exp_c[i], exp_d[i]);
            end
            tick();
        end
        n_checks++;
        if (out_if.dv_out !== 1'b0) begin n_fail++; $display("FAIL rr_drain got %0b want 0", out_if.dv_out); end
    endtask

    task automatic test_enable();
        do_reset();
        data_valid_in = 6'b000010;
        data_a_in     = 18'sd50;
        tick();
        data_valid_in = 6'b000001;
        data_a_in     = 18'sd60;
        tick();
        data_valid_in = '0;
        update_in     = 1'b1;
        chan_en_in    = 6'b111110;
        tick();
        update_in     = 1'b0;
        data_valid_in = 6'b000001;
        data_a_in     = 18'sd70;
        tick();
        data_valid_in = '0;
        n_checks++;
        if (out_if.chan_out !== 3'd1 || out_if.data_out !== 18'sd50) begin
            n_fail++;
            $display("FAIL en_hold got ch=%0d d=%0d want ch=1 d=50", out_if.chan_out, out_if.data_out);
        end
        out_if.ready_in = 1'b1;
        tick();
        n_checks++;
        if (out_if.dv_out !== 1'b0) begin n_fail++; $display("FAIL en_dropped got %0b want 0", out_if.dv_out); end
        repeat (3) tick();
        n_checks++;
        if (out_if.dv_out !== 1'b0) begin n_fail++; $display("FAIL en_quiet got %0b want 0", out_if.dv_out); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        data_valid_in = 6'b001001;
        data_a_in     = 18'sd5;
        data_b_in     = 18'sd6;
        tick();
        data_valid_in = 6'b010010;
        tick();
        data_valid_in = '0;
        n_checks++;
        if (out_if.dv_out !== 1'b1) begin n_fail++; $display("FAIL mid_loaded got %0b want 1", out_if.dv_out); end
        n_reset_in = 1'b0;
        #1;
        n_checks++;
        if (out_if.dv_out !== 1'b0 || out_if.data_out !== 18'sd0 || out_if.chan_out !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_async got dv=%0b ch=%0d d=%0d want 0 0 0",
                     out_if.dv_out, out_if.chan_out, out_if.data_out);
        end
        tick();
        n_reset_in      = 1'b1;
        out_if.ready_in = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (out_if.dv_out !== 1'b0 || ovr_out !== 6'b0) begin
            n_fail++;
            $display("FAIL mid_after got dv=%0b ovr=%b want dv=0 ovr=000000", out_if.dv_out, ovr_out);
        end
        data_valid_in = 6'b000100;
        data_a_in     = 18'sd77;
        tick();
        data_valid_in = '0;
        tick();
        n_checks++;
        if (out_if.dv_out !== 1'b1 || out_if.chan_out !== 3'd2 || out_if.data_out !== 18'sd77) begin
            n_fail++;
            $display("FAIL mid_new got dv=%0b ch=%0d d=%0d want dv=1 ch=2 d=77",
                     out_if.dv_out, out_if.chan_out, out_if.data_out);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pair();
        test_overrun();
        test_same_cycle();
        test_round_robin();
        test_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
